// File: rtl/mem_pkg.sv
// Shared sizing defaults and word type for the CPU data memory.
package mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int DEPTH      = 1024;
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int WORD_SHIFT = 2;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Byte address to word index plus range flag, shared by the write and read paths.
module mem_addr_decode #(
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int DEPTH      = mem_pkg::DEPTH,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [IDX_W-1:0]      idx,
    output logic                  in_range
);

    import mem_pkg::*;

    // Any set bit above the index field means the word lies beyond DEPTH; no aliasing.
    always_comb begin
        idx      = Address[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
        in_range = ~|Address[ADDR_WIDTH-1:IDX_W+WORD_SHIFT];
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised, byte-addressed data memory: synchronous write, combinational read,
// asynchronous clear of the whole array.
module data_memory #(
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int DEPTH      = mem_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  WE,
    output logic [DATA_WIDTH-1:0] dataout
);

    import mem_pkg::*;

    localparam int LOC_IDX_W = $clog2(DEPTH);

    logic [LOC_IDX_W-1:0]  idx;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    mem_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (LOC_IDX_W)
    ) u_decode (
        .Address  (Address),
        .idx      (idx),
        .in_range (in_range)
    );

    // Storage array: cleared immediately by rst, written only for in-range enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE && in_range) begin
            mem[idx] <= data;
        end
    end

    // Read mux with a zero default for addresses beyond the array.
    always_comb begin
        dataout = '0;
        if (in_range) begin
            dataout = mem[idx];
        end else begin
            dataout = '0;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read data, a monitor pops and compares.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] data;
    logic        WE;
    logic [31:0] dataout;

    logic [31:0] exp_q [$];
    string       name_q [$];
    event        chk_ev;
    int          n_pass;
    int          n_total;

    data_memory dut (
        .clk     (clk),
        .rst     (rst),
        .Address (Address),
        .data    (data),
        .WE      (WE),
        .dataout (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample 1 ns after each request and compare against the queued expectation.
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_total++;
                if (dataout === e) n_pass++;
                else $display("FAIL %s: dataout=%h expected=%h", nm, dataout, e);
            end
        end
    end

    task automatic expect_now(input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        ->chk_ev;
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) #1;
        if (exp_q.size() != 0) begin
            $display("FAIL %s: monitor timeout, pending=%0d expected=%h", nm, exp_q.size(), e);
            n_total++;
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic check_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        Address = a;
        WE      = 1'b0;
        expect_now(e, $sformatf("%s@%0d", nm, a));
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address = a;
        data    = d;
        WE      = 1'b1;
        @(posedge clk);
        #1;
        WE      = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        WE      = 1'b0;
        Address = 32'd0;
        data    = 32'd0;
        #2;
        rst = 1'b0;

        check_read(32'd0,    32'd0, "reset");
        check_read(32'd4,    32'd0, "reset");
        check_read(32'd4092, 32'd0, "reset");

        for (int i = 0; i < 10; i++) write_word(32'(i * 4), 32'(i + 1));
        for (int i = 0; i < 10; i++) check_read(32'(i * 4), 32'(i + 1), "fill");

        check_read(32'd40,   32'd0, "unwritten");
        check_read(32'd1000, 32'd0, "unwritten");
        check_read(32'd4092, 32'd0, "unwritten");

        write_word(32'd4096, 32'hDEADBEEF);
        check_read(32'd4096,  32'd0, "oor_read");
        check_read(32'd10000, 32'd0, "oor_read");
        check_read(32'd0,     32'd1, "oor_no_alias");

        write_word(32'd6, 32'h0000_0055);
        check_read(32'd4, 32'h0000_0055, "misaligned");
        check_read(32'd5, 32'h0000_0055, "misaligned");
        check_read(32'd7, 32'h0000_0055, "misaligned");

        @(negedge clk);
        Address = 32'd4;
        data    = 32'h0000_00AA;
        WE      = 1'b1;
        expect_now(32'h0000_0055, "overwrite_before_edge");
        @(posedge clk);
        #1;
        WE = 1'b0;
        expect_now(32'h0000_00AA, "overwrite_after_edge");

        check_read(32'd36, 32'd10, "pre_reset");
        @(negedge clk);
        Address = 32'd0;
        #1;
        rst = 1'b1;
        expect_now(32'd0, "async_reset_no_edge");
        @(negedge clk);
        rst = 1'b0;
        check_read(32'd0,  32'd0, "after_reset");
        check_read(32'd4,  32'd0, "after_reset");
        check_read(32'd36, 32'd0, "after_reset");

        write_word(32'd8, 32'd7);
        check_read(32'd8, 32'd7, "write_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
